can_bit_timing: RTL and testbench
=================================

# can_bit_timing

Receive-side bit timing unit for the CAN controller. It sits directly upstream of the bit destuffer: it synchronizes the raw `rx` pin, divides the system clock into time quanta, and runs the SYNC/SEG1/SEG2 bit-time state machine. It performs hard synchronization and resynchronization on recessive-to-dominant edges. Its outputs are a one-cycle `sample_point` strobe plus the sampled bit value, which the destuffer consumes as `sample_point`/`bit_in`. A `tx_point` strobe marks each bit start for the transmit path.

## Interface
- `BRP`, default 2: clocks per time quantum (tq); legal range 1..64.
- `TSEG1`, default 5: SEG1 length in tq (PROP+PHASE1); legal range 2..16.
- `TSEG2`, default 2: SEG2 length in tq; legal range 1..8.
- `SJW`, default 1: sync jump width in tq; legal range 1..min(4,TSEG2).
- `clk`  in  1  system clock. There is one clock; all logic is on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `rx`  in  1  raw CAN bus input, asynchronous (1 = recessive).
- `hard_sync_en`  in  1  bus idle / start-of-frame expected; enables hard sync on the next falling edge.
- `sample_point`  out  1  one-cycle strobe; `bit_out` is valid and newly updated.
- `bit_out`  out  1  bus value sampled at the latest sample point; held between strobes.
- `tx_point`  out  1  one-cycle strobe in the first clock of each SYNC segment.

## Operation
- **Input synchronizer:** `rx` passes through a 2-flop synchronizer to give `rx_s`. `rx_s` is registered again to give `rx_d`. `edge = rx_d & ~rx_s`, a recessive-to-dominant edge.
- **Prescaler:** `presc` counts 0..BRP-1 and wraps. `tq_tick = (presc == BRP-1)`.
- **State machine:** states SYNC, SEG1, SEG2. `seg_cnt` counts tq within the current segment. All transitions occur on `tq_tick`.
  - SYNC lasts 1 tq, then goes to SEG1.
  - SEG1 lasts TSEG1+`ext` tq, then goes to SEG2 and samples.
  - SEG2 lasts TSEG2−`shr` tq, then goes to SYNC.
- **Sample:** on the clock edge where the last SEG1 tq completes, `bit_out <= rx_s` and `sample_point <= 1` for one cycle.
- **Bit start:** on the clock edge entering SYNC, `tx_point <= 1` for one cycle.
- **Sync gating:** `sync_done` is set by any hard sync or resync and cleared on entry to SYNC, which allows at most one synchronization per bit. An edge is acted on only if `sync_done == 0`.
- **Hard sync** (`edge & hard_sync_en`), in any state:
  - `presc <= 0`, state <= SYNC, `seg_cnt <= 0`, `ext`/`shr` <= 0.
  - `tx_point` pulses.
  - `sync_done <= 1`.
- **Resync** (`edge & ~hard_sync_en & bit_out == 1`):
  - **In SYNC:** phase error is 0. No adjustment is made, but `sync_done` is still set.
  - **In SEG1:** `e = seg_cnt + 1`, and `ext <= min(e, SJW)`.
  - **In SEG2:** `e = TSEG2 − seg_cnt`, the remaining tq including the current one.
    - If `e <= SJW`, the unit behaves exactly as a hard sync: the edge tq becomes SYNC.
    - Otherwise `shr <= SJW`.
- **Ignored edges:** edges when the last sampled `bit_out == 0` are ignored.
- **Width rules:** `presc` is clog2(BRP) bits and `seg_cnt` is 5 bits. `ext` and `shr` are 3 bits and saturate at SJW. Out-of-range parameters are a `$fatal` at elaboration.

## Timing
- **Reset values:**
  - `sample_point = 0`, `tx_point = 0`, `bit_out = 1`.
  - State = SYNC, `presc = 0`, `seg_cnt = 0`, `ext = shr = 0`, `sync_done = 0`.
  - Synchronizer flops and `rx_d` = 1.
- **Start after reset:** the first `tx_point` occurs one clock after `rst_n` deasserts.
- **Nominal bit time:** (1+TSEG1+TSEG2)·BRP clocks, which is 16 with the defaults.
- **Bit phase:** `sample_point` occurs (1+TSEG1)·BRP clocks after `tx_point`, which is 12 with the defaults.
- **Edge latency:** `rx` fall → `edge` visible is 2 clocks. A sync-triggered `tx_point` is high 3 clocks after the `rx` fall.
- **Reset mid-bit:** asynchronous reset immediately restores all reset values and aborts any pending `ext`/`shr`. The strobes drop in the same instant.
- **Simultaneous events:** an edge coincident with the SEG1→SEG2 `tq_tick` is treated as in SEG1. An edge coincident with the SEG2→SYNC tick is treated as in SEG2. Hard sync overrides an in-progress sample transition; no `sample_point` is issued on that edge.

## Test plan
1. **Idle bus.** Stimulus: defaults, `rx = 1` held after reset. Required response: `tx_point` every 16 clocks; `sample_point` 12 clocks after each `tx_point`; `bit_out = 1`.
2. **Hard sync.** Stimulus: `hard_sync_en = 1`, `rx` falls mid-SEG2 and stays 0. Required response: `tx_point` 3 clocks after the fall; `sample_point` 12 clocks later with `bit_out = 0`.
3. **Positive resync.** Stimulus: `bit_out = 1`, `rx` falls during the 3rd SEG1 tq, SJW = 1. Required response: that bit's `sample_point` lands 14 clocks after its `tx_point` (ext = 1 tq); the bit lasts 18 clocks.
4. **Negative resync.** Stimulus: `rx` falls in the last SEG2 tq (e = 1 ≤ SJW). Required response: immediate new SYNC; `tx_point` 3 clocks after the fall; next sample 12 clocks after that.
5. **Ignored edges.** Stimulus: an edge while `bit_out = 0`, and a second edge within the same bit after a resync. Required response: no change to bit length (16 clocks).
6. **Reset mid-SEG1.** Stimulus: `rst_n` pulsed low for 3 clocks. Required response: outputs equal the reset values during reset; `tx_point` 1 clock after release; cadence as in scenario 1.

Source files
------------

// File: rtl/can_bit_timing.sv
// can_bit_timing: CAN receive bit timing - rx synchronizer, tq prescaler and
// SYNC/SEG1/SEG2 sequencing with hard sync and SJW-limited resynchronization.
module can_bit_timing #(
  parameter int BRP   = 2,
  parameter int TSEG1 = 5,
  parameter int TSEG2 = 2,
  parameter int SJW   = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic rx,
  input  logic hard_sync_en,
  output logic sample_point,
  output logic bit_out,
  output logic tx_point
);
  localparam int PW = (BRP > 1) ? $clog2(BRP) : 1;
  localparam logic [PW-1:0] P_LAST = PW'(BRP - 1);
  localparam logic [PW-1:0] P_ONE = PW'(1);
  localparam logic [4:0] T1 = 5'(TSEG1);
  localparam logic [4:0] T2 = 5'(TSEG2);
  localparam logic [4:0] SJ = 5'(SJW);
  localparam logic [2:0] SJ3 = 3'(SJW);

  if (BRP < 1 || BRP > 64 || TSEG1 < 2 || TSEG1 > 16 || TSEG2 < 1 || TSEG2 > 8 ||
      SJW < 1 || SJW > 4 || SJW > TSEG2) begin : g_bad_param
    $fatal(1, "can_bit_timing: parameter out of range");
  end

  typedef enum logic [1:0] {SYNC, SEG1, SEG2} state_t;
  state_t state, state_n;
  logic rx_m, rx_s, rx_d, rx_fall, tq_tick, run;
  logic act, resync, hard, seg_end;
  logic [PW-1:0] presc, presc_n;
  logic [4:0] seg_cnt, seg_n, e1, e2, seg_len;
  logic [2:0] ext, ext_n, shr, shr_n;
  logic sync_done, sync_n, sp_n, tp_n, bit_n;

  assign rx_fall = rx_d & ~rx_s;
  assign tq_tick = run & (presc == P_LAST);
  assign e1 = seg_cnt + 5'd1;
  assign e2 = T2 - seg_cnt;
  assign act = rx_fall & ~sync_done;
  assign resync = act & ~hard_sync_en & bit_out;
  // a late edge in SEG2 (within SJW of the bit end) restarts the bit like a hard sync
  assign hard = (act & hard_sync_en) | (resync & (state == SEG2) & (e2 <= SJ));

  always_comb begin
    state_n = state;
    presc_n = (tq_tick || !run) ? '0 : presc + P_ONE;
    seg_n = seg_cnt;
    ext_n = (resync && state == SEG1) ? ((e1 > SJ) ? SJ3 : e1[2:0]) : ext;
    shr_n = (resync && state == SEG2) ? SJ3 : shr;
    sync_n = sync_done | resync;
    sp_n = 1'b0;
    tp_n = ~run;
    bit_n = bit_out;
    seg_len = (state == SYNC) ? 5'd1 : (state == SEG1) ? T1 + {2'b0, ext_n} : T2 - {2'b0, shr_n};
    seg_end = tq_tick && (seg_cnt == seg_len - 5'd1);
    if (hard) begin
      presc_n = '0;
      state_n = SYNC;
      seg_n = '0;
      ext_n = '0;
      shr_n = '0;
      tp_n = 1'b1;
      sync_n = 1'b1;
    end else if (tq_tick) begin
      seg_n = seg_end ? 5'd0 : seg_cnt + 5'd1;
      if (seg_end) begin
        state_n = (state == SYNC) ? SEG1 : (state == SEG1) ? SEG2 : SYNC;
        sp_n = (state == SEG1);
        bit_n = (state == SEG1) ? rx_s : bit_out;
        if (state == SEG2) begin
          tp_n = 1'b1;
          sync_n = 1'b0;
          ext_n = '0;
          shr_n = '0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
      rx_d <= 1'b1;
      run <= 1'b0;
      state <= SYNC;
      presc <= '0;
      seg_cnt <= '0;
      ext <= '0;
      shr <= '0;
      sync_done <= 1'b0;
      sample_point <= 1'b0;
      tx_point <= 1'b0;
      bit_out <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
      rx_d <= rx_s;
      run <= 1'b1;
      state <= state_n;
      presc <= presc_n;
      seg_cnt <= seg_n;
      ext <= ext_n;
      shr <= shr_n;
      sync_done <= sync_n;
      sample_point <= sp_n;
      tx_point <= tp_n;
      bit_out <= bit_n;
    end
  end
endmodule

// File: tb/tb_can_bit_timing.sv
// tb_can_bit_timing: directed bit-timing scenarios checked against a timestamp model
module tb_can_bit_timing;
  localparam int BRP = 2, TSEG1 = 5, TSEG2 = 2, SJW = 1;
  logic clk = 1'b0;
  logic rst_n, rx, hard_sync_en, sample_point, bit_out, tx_point;
  int passes = 0, total = 0, cyc = 0;
  bit rxh [0:4095];
  bit hsh [0:4095];
  int k, ext, shr, j, q;
  bit sd, bo = 1'b1, started = 1'b0, e_tp, e_sp, hard;

  can_bit_timing #(.BRP(BRP), .TSEG1(TSEG1), .TSEG2(TSEG2), .SJW(SJW)) dut (
    .clk(clk), .rst_n(rst_n), .rx(rx), .hard_sync_en(hard_sync_en),
    .sample_point(sample_point), .bit_out(bit_out), .tx_point(tx_point)
  );

  always #5 clk = ~clk;

  task automatic chk(input logic [31:0] act, input logic [31:0] exp, input string nm);
    total++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
  endtask

  // Model in bit-time arithmetic: bit start k, tq index of the edge, sample/end timestamps.
  always @(posedge clk) begin
    rxh[cyc] = rx;
    hsh[cyc] = hard_sync_en;
    cyc++;
    e_tp = 1'b0;
    e_sp = 1'b0;
    hard = 1'b0;
    if (!rst_n) begin
      started = 1'b0; bo = 1'b1; ext = 0; shr = 0; sd = 1'b0;
    end else if (!started) begin
      started = 1'b1; k = cyc; e_tp = 1'b1;
    end else begin
      j = cyc;
      q = (j - 1 - k) / BRP;
      if (rxh[j-4] && !rxh[j-3] && !sd) begin
        if (hsh[j-1]) hard = 1'b1;
        else if (bo) begin
          sd = 1'b1;
          if (q >= 1 && q <= TSEG1 + ext) ext = (q < SJW) ? q : SJW;
          else if (q > TSEG1 + ext) begin
            if (1 + TSEG1 + ext + TSEG2 - q <= SJW) hard = 1'b1;
            else shr = SJW;
          end
        end
      end
      if (hard) begin
        k = j; ext = 0; shr = 0; sd = 1'b1; e_tp = 1'b1;
      end else if (j == k + BRP * (1 + TSEG1 + ext)) begin
        e_sp = 1'b1; bo = rxh[j-3];
      end else if (j == k + BRP * (1 + TSEG1 + ext + TSEG2 - shr)) begin
        k = j; e_tp = 1'b1; ext = 0; shr = 0; sd = 1'b0;
      end
    end
    #1;
    chk(tx_point, e_tp, $sformatf("tx_point@%0d", cyc));
    chk(sample_point, e_sp, $sformatf("sample_point@%0d", cyc));
    chk(bit_out, bo, $sformatf("bit_out@%0d", cyc));
  end

  // Starts on the negedge of a tx_point cycle; ends on the negedge of the next one.
  task automatic check_bit(input int fall_at, input int rise_at, input int sp_exp,
                           input int len_exp, input logic b_exp, input string nm);
    int sp_at = -1, len = -1;
    logic b = 1'bx;
    for (int i = 0; i <= 40 && len < 0; i++) begin
      if (i > 0) @(negedge clk);
      if (i == fall_at) rx = 1'b0;
      if (i == rise_at) rx = 1'b1;
      if (i > 0 && sample_point) begin sp_at = i; b = bit_out; end
      if (i > 0 && tx_point) len = i;
    end
    chk(sp_at, sp_exp, {nm, " sample offset"});
    chk(len, len_exp, {nm, " bit length"});
    chk(b, b_exp, {nm, " sampled bit"});
  endtask

  initial begin
    rst_n = 1'b0; rx = 1'b1; hard_sync_en = 1'b0;
    repeat (3) @(negedge clk);
    chk(tx_point, 0, "reset tx_point");
    chk(sample_point, 0, "reset sample_point");
    chk(bit_out, 1, "reset bit_out");
    rst_n = 1'b1;
    @(negedge clk);
    chk(tx_point, 1, "first tx_point");
    check_bit(-1, -1, 12, 16, 1'b1, "idle0");
    check_bit(-1, -1, 12, 16, 1'b1, "idle1");
    check_bit(4, -1, 14, 18, 1'b0, "pos resync");
    check_bit(5, 1, 12, 16, 1'b0, "edge with bit_out 0");
    check_bit(-1, 0, 12, 16, 1'b1, "recover 1");
    check_bit(14, -1, 12, 16, 1'b1, "edge into sync");
    check_bit(6, 2, 12, 16, 1'b0, "second edge ignored");
    check_bit(-1, 0, 12, 16, 1'b1, "recover 1b");
    check_bit(12, -1, 12, 15, 1'b1, "neg resync");
    check_bit(-1, -1, 12, 16, 1'b0, "after neg resync");
    hard_sync_en = 1'b1;
    check_bit(-1, 0, 12, 16, 1'b1, "pre hard sync");
    check_bit(10, -1, 12, 13, 1'b1, "hard sync");
    check_bit(-1, -1, 12, 16, 1'b0, "after hard sync");
    hard_sync_en = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    rx = 1'b1;
    #1;
    chk(tx_point, 0, "mid reset tx_point");
    chk(sample_point, 0, "mid reset sample_point");
    chk(bit_out, 1, "mid reset bit_out");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk(tx_point, 1, "tx_point after release");
    check_bit(-1, -1, 12, 16, 1'b1, "post reset0");
    check_bit(-1, -1, 12, 16, 1'b1, "post reset1");
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
endmodule
